// File: rtl/pad_scan_ctrl_if.sv
// Joypad types and the CPU/HMI-side bundle of pad_scan_ctrl.
// master drives requests and the HMI snapshot; slave is the controller.
package pad_scan_pkg;
  typedef struct packed {
    logic [6:1] b;
    logic       select;
    logic       run;
    logic       u;
    logic       r;
    logic       d;
    logic       l;
    logic       mode1;
    logic       mode2;
  } joypad_t;

  typedef struct packed {
    joypad_t jp1;
    joypad_t jp2;
  } hmi_t;
endpackage

interface pad_scan_ctrl_if;
  import pad_scan_pkg::*;

  hmi_t        hmi;
  logic        trig;
  logic        port;
  logic        auto_en;
  logic        irq_clr;
  logic        busy;
  logic        done;
  logic [31:0] data;
  logic        dport;
  logic        irq;

  modport master (
    output hmi, trig, port, auto_en, irq_clr,
    input  busy, done, data, dport, irq
  );

  modport slave (
    input  hmi, trig, port, auto_en, irq_clr,
    output busy, done, data, dport, irq
  );
endinterface

// File: rtl/pad_scan_ctrl.sv
// Joypad serial-link emulator: latches one pad, shifts a 32-bit frame at DIV clocks/bit.
// Optional auto-scan is compiled in with macro PAD_SCAN_AUTO_EN.
module pad_scan_ctrl #(
  parameter int DIV      = 16,
  parameter int AUTO_GAP = 1024
) (
  input  logic            clk,
  input  logic            res_n,
  pad_scan_ctrl_if.slave  bus
);
  import pad_scan_pkg::*;

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_FIN} state_t;

  state_t          state_reg;
  logic [31:0]     tx_reg;
  logic [31:0]     rx_reg;
  logic [DW-1:0]   div_cnt_reg;
  logic [4:0]      bit_cnt_reg;
  logic            port_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [31:0]     data_reg;
  logic            dport_reg;
  logic            irq_reg;

  logic            start_trig;
  logic            start_port;
  joypad_t         sel_pad;
  logic [31:0]     frame;

  assign sel_pad = port_reg ? bus.hmi.jp2 : bus.hmi.jp1;
  assign frame   = {4'hF, 13'b0, sel_pad.mode2, 1'b0, sel_pad.mode1,
                    sel_pad.l, sel_pad.d, sel_pad.r, sel_pad.u,
                    sel_pad.run, sel_pad.select, sel_pad.b};

`ifdef PAD_SCAN_AUTO_EN
  localparam int GW = (AUTO_GAP > 1) ? $clog2(AUTO_GAP + 1) : 1;

  logic [GW-1:0] gap_cnt_reg;
  logic          auto_port_reg;

  always_comb begin
    start_trig = 1'b0;
    start_port = bus.port;
    if (state_reg == S_IDLE) begin
      if (bus.trig) begin
        start_trig = 1'b1;
      end else if (bus.auto_en && gap_cnt_reg == GW'(AUTO_GAP - 1)) begin
        start_trig = 1'b1;
        start_port = auto_port_reg;
      end
    end
  end

  // Gap counts consecutive idle cycles with AUTO high; any start restarts it.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      gap_cnt_reg   <= '0;
      auto_port_reg <= 1'b0;
    end else begin
      if (!bus.auto_en || state_reg != S_IDLE || start_trig)
        gap_cnt_reg <= '0;
      else
        gap_cnt_reg <= gap_cnt_reg + 1'b1;

      if (!bus.auto_en)
        auto_port_reg <= 1'b0;
      else if (start_trig && !bus.trig)
        auto_port_reg <= ~auto_port_reg;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = bus.auto_en ^ (AUTO_GAP == 0);

  always_comb begin
    start_trig = (state_reg == S_IDLE) && bus.trig;
    start_port = bus.port;
  end
`endif

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_reg   <= S_IDLE;
      tx_reg      <= '0;
      rx_reg      <= '0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      port_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      data_reg    <= '0;
      dport_reg   <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.irq_clr)
        irq_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start_trig) begin
            state_reg <= S_LATCH;
            port_reg  <= start_port;
            busy_reg  <= 1'b1;
          end
        end
        S_LATCH: begin
          tx_reg      <= frame;
          div_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          state_reg   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt_reg == DW'(DIV - 1)) begin
            div_cnt_reg <= '0;
            rx_reg      <= {tx_reg[0], rx_reg[31:1]};
            tx_reg      <= tx_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            // Last bit: publish the completed word so it is visible in FIN.
            if (bit_cnt_reg == 5'd31) begin
              state_reg <= S_FIN;
              data_reg  <= {tx_reg[0], rx_reg[31:1]};
              dport_reg <= port_reg;
              done_reg  <= 1'b1;
              irq_reg   <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        S_FIN: begin
          state_reg <= S_IDLE;
          irq_reg   <= 1'b1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.data  = data_reg;
  assign bus.dport = dport_reg;
  assign bus.irq   = irq_reg;
endmodule

// File: tb/tb_pad_scan_ctrl.sv
// Self-checking bench for pad_scan_ctrl: per-cycle scan model plus literal pins.
module tb_pad_scan_ctrl;
  import pad_scan_pkg::*;

  localparam int DIV  = 4;
  localparam int GAP  = 8;
  localparam int FINK = 32 * DIV + 1;   // FIN offset from the LATCH cycle

  logic clk = 1'b0;
  logic res_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  pad_scan_ctrl_if bus ();

  pad_scan_ctrl #(.DIV(DIV), .AUTO_GAP(GAP)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_frame(input joypad_t p);
    logic [31:0] f;
    f = 32'hF000_0000;
    for (int i = 1; i <= 6; i++)
      if (p.b[i]) f = f + (32'd1 << (i - 1));
    if (p.select) f = f + 32'h40;
    if (p.run)    f = f + 32'h80;
    if (p.u)      f = f + 32'h100;
    if (p.r)      f = f + 32'h200;
    if (p.d)      f = f + 32'h400;
    if (p.l)      f = f + 32'h800;
    if (p.mode1)  f = f + 32'h1000;
    if (p.mode2)  f = f + 32'h4000;
    return f;
  endfunction

  // Model state
  logic        m_active = 1'b0;
  int          m_l = 0;
  logic        m_port = 1'b0;
  logic [31:0] m_frame = '0;
  logic [31:0] m_data = '0;
  logic        m_dport = 1'b0;
  logic        m_irq = 1'b0;
  int          m_gap = 0;
  logic        m_auto_port = 1'b0;

  int   done_cnt = 0;
  int   done_cyc[$];
  logic done_port[$];

  always @(negedge clk) begin : model
    int   k;
    logic prot;
    if (cyc > 0) begin
      k = 0;
      if (m_active) begin
        k = cyc - m_l;
        if (k == 0) m_frame = mk_frame(m_port ? bus.hmi.jp2 : bus.hmi.jp1);
        if (k == FINK) begin
          m_data  = m_frame;
          m_dport = m_port;
          m_irq   = 1'b1;
        end
        if (k == FINK + 1) m_active = 1'b0;
      end

      check("busy",  {31'b0, bus.busy},  {31'b0, m_active && k <= 32 * DIV});
      check("done",  {31'b0, bus.done},  {31'b0, m_active && k == FINK});
      check("data",  bus.data,           m_data);
      check("dport", {31'b0, bus.dport}, {31'b0, m_dport});
      check("irq",   {31'b0, bus.irq},   {31'b0, m_irq});

      if (bus.done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        done_port.push_back(bus.dport);
        $display("scan cyc=%0d dport=%0d data=%h", cyc, bus.dport, bus.data);
      end

      if (!res_n) begin
        m_active = 1'b0; m_data = '0; m_dport = 1'b0; m_irq = 1'b0;
        m_gap = 0; m_auto_port = 1'b0;
      end else begin
        prot = m_active && (k == FINK - 1 || k == FINK);
        if (bus.irq_clr && !prot) m_irq = 1'b0;
        if (!m_active) begin
          if (bus.trig) begin
            m_active = 1'b1; m_l = cyc + 1; m_port = bus.port; m_gap = 0;
          end
`ifdef PAD_SCAN_AUTO_EN
          else if (bus.auto_en) begin
            m_gap++;
            if (m_gap == GAP) begin
              m_active = 1'b1; m_l = cyc + 1; m_port = m_auto_port;
              m_auto_port = ~m_auto_port; m_gap = 0;
            end
          end
`endif
        end else begin
          m_gap = 0;
        end
        if (!bus.auto_en) begin
          m_gap = 0; m_auto_port = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_trig(input logic p);
    bus.port = p;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
  endtask

  initial begin : stim
    int t0;
    int d0;
    int b0;
    bus.hmi = '0; bus.trig = 1'b0; bus.port = 1'b0;
    bus.auto_en = 1'b0; bus.irq_clr = 1'b0;
    repeat (3) tick();
    res_n = 1'b1;
    tick();
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_data", bus.data, 32'h0);
    check("rst_irq",  {31'b0, bus.irq}, 32'd0);

    // Scan 1: jp1 b1/run/l
    bus.hmi.jp1.b[1] = 1'b1; bus.hmi.jp1.run = 1'b1; bus.hmi.jp1.l = 1'b1;
    t0 = cyc;
    pulse_trig(1'b0);
    wait_to(t0 + 129);
    check("s1_busy_last", {31'b0, bus.busy}, 32'd1);
    wait_to(t0 + 130);
    check("s1_done", {31'b0, bus.done}, 32'd1);
    check("s1_data", bus.data, 32'hF000_0881);
    check("s1_dport", {31'b0, bus.dport}, 32'd0);
    check("s1_irq", {31'b0, bus.irq}, 32'd1);
    wait_to(t0 + 133);

    // Scan 2: jp2 mode2/u, jp2 cleared mid-scan
    bus.hmi.jp2.mode2 = 1'b1; bus.hmi.jp2.u = 1'b1;
    t0 = cyc;
    pulse_trig(1'b1);
    wait_to(t0 + 10);
    bus.hmi.jp2 = '0;
    wait_to(t0 + 131);
    check("s2_data", bus.data, 32'hF000_4100);
    check("s2_dport", {31'b0, bus.dport}, 32'd1);
    wait_to(t0 + 133);

    // IRQ_CLR across FIN is overridden; one cycle later it clears
    t0 = cyc;
    pulse_trig(1'b0);
    wait_to(t0 + 129);
    bus.irq_clr = 1'b1;
    wait_to(t0 + 131);
    bus.irq_clr = 1'b0;
    check("irq_hold", {31'b0, bus.irq}, 32'd1);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    check("irq_clr", {31'b0, bus.irq}, 32'd0);
    wait_to(t0 + 134);

    // Retriggers while busy are dropped; earliest retrigger accepted
    d0 = done_cnt;
    t0 = cyc;
    pulse_trig(1'b0);
    wait_to(t0 + 5);   pulse_trig(1'b1);
    wait_to(t0 + 129); pulse_trig(1'b1);
    wait_to(t0 + 131);
    check("rt_one_done", done_cnt - d0, 32'd1);
    check("rt_done_cyc", done_cyc[done_cyc.size() - 1] - t0, 32'd130);
    pulse_trig(1'b0);
    wait_to(t0 + 264);
    check("rt_second_cyc", done_cyc[done_cyc.size() - 1] - t0, 32'd261);

    // Reset mid-scan
    d0 = done_cnt;
    t0 = cyc;
    pulse_trig(1'b1);
    wait_to(t0 + 60);
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    check("mr_busy", {31'b0, bus.busy}, 32'd0);
    check("mr_data", bus.data, 32'h0);
    check("mr_irq", {31'b0, bus.irq}, 32'd0);
    wait_to(t0 + 140);
    check("mr_no_done", done_cnt - d0, 32'd0);
    bus.hmi.jp1 = '0; bus.hmi.jp1.select = 1'b1;
    t0 = cyc;
    pulse_trig(1'b0);
    wait_to(t0 + 131);
    check("mr_recover", bus.data, 32'hF000_0040);
    check("mr_recover_cnt", done_cnt - d0, 32'd1);
    wait_to(t0 + 133);

    // Auto-scan
    d0 = done_cnt;
    b0 = done_cyc.size();
    t0 = cyc;
    bus.auto_en = 1'b1;
`ifdef PAD_SCAN_AUTO_EN
    wait_to(t0 + 3 * 138 + 4);
    bus.auto_en = 1'b0;
    check("auto_cnt", done_cnt - d0, 32'd3);
    if (done_cnt - d0 >= 3) begin
      check("auto_first", done_cyc[b0] - t0, 32'd138);
      check("auto_gap", done_cyc[b0 + 1] - done_cyc[b0], 32'd138);
      check("auto_p0", {31'b0, done_port[b0]}, 32'd0);
      check("auto_p1", {31'b0, done_port[b0 + 1]}, 32'd1);
      check("auto_p2", {31'b0, done_port[b0 + 2]}, 32'd0);
    end
    wait_to(cyc + 140);
`else
    wait_to(t0 + 300);
    bus.auto_en = 1'b0;
    check("auto_ignored", done_cnt - d0, 32'd0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
